// File: rtl/boot_bus_translator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : boot_bus_pkg                                                 |
// | Description : Shared types and constants for the boot-control to          |
// |               AHB-Lite burst translator: HTRANS encoding, FSM state        |
// |               encoding, fixed HSIZE/HBURST values and the beat count.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package boot_bus_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  // FSM state encoding kept as explicit-width constants for compatibility
  // with existing tooling that inspects raw state values.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_BURST = 3'd2;
  localparam state_t ST_LAST  = 3'd3;
  localparam state_t ST_ERR   = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  localparam logic [2:0] HSIZE_WORD   = 3'b010;
  localparam logic [2:0] HBURST_INCR4 = 3'b011;

  localparam int BEATS = 4;

endpackage
`default_nettype wire

// File: rtl/boot_bus_translator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : boot_bus_translator_if                                       |
// | Description : Bundles the boot-control request bus and the AHB-Lite        |
// |               master bus of the translator.                                |
// |   master modport : translator side (responder on boot-control bus,         |
// |                    master on AHB-Lite)                                     |
// |   slave modport  : environment side (boot control + AHB-Lite slave)        |
// | Signals     : bootControl_bus_go/addr/write/RW (request in),               |
// |               bootControl_bus_done/rdData/err (completion out),            |
// |               HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA (AHB out),           |
// |               HRDATA/HREADY/HRESP (AHB in)                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface boot_bus_translator_if
  import boot_bus_pkg::*;
#(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pAHB_DATA_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 128
);

  logic                          bootControl_bus_go;
  logic [pAHB_ADDR_WIDTH-1:0]    bootControl_bus_addr;
  logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_write;
  logic                          bootControl_bus_RW;
  logic                          bootControl_bus_done;
  logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_rdData;
  logic                          bootControl_bus_err;

  logic [pAHB_ADDR_WIDTH-1:0]    HADDR;
  htrans_t                       HTRANS;
  logic                          HWRITE;
  logic [2:0]                    HSIZE;
  logic [2:0]                    HBURST;
  logic [pAHB_DATA_WIDTH-1:0]    HWDATA;
  logic [pAHB_DATA_WIDTH-1:0]    HRDATA;
  logic                          HREADY;
  logic                          HRESP;

  modport master (
    input  bootControl_bus_go, bootControl_bus_addr, bootControl_bus_write,
           bootControl_bus_RW, HRDATA, HREADY, HRESP,
    output bootControl_bus_done, bootControl_bus_rdData, bootControl_bus_err,
           HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

  modport slave (
    output bootControl_bus_go, bootControl_bus_addr, bootControl_bus_write,
           bootControl_bus_RW, HRDATA, HREADY, HRESP,
    input  bootControl_bus_done, bootControl_bus_rdData, bootControl_bus_err,
           HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

endinterface
`default_nettype wire

// File: rtl/boot_bus_translator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : boot_bus_translator                                          |
// | Description : Turns each 128-bit boot-control request into a single        |
// |               AHB-Lite INCR4 burst of four 32-bit beats and returns the    |
// |               assembled read payload (or a completion) with a one-cycle    |
// |               done pulse. err qualifies done (1 = burst aborted).          |
// | Ports       : clk, rst (async, active-high)                                |
// |               bus  boot_bus_translator_if.master                           |
// |                 request : bootControl_bus_go/addr/write/RW                 |
// |                 reply   : bootControl_bus_done/rdData/err                  |
// |                 AHB     : HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA out,     |
// |                           HRDATA/HREADY/HRESP in                           |
// | Options     : BUS_TIMEOUT_EN - abort a beat after pTIMEOUT_CYCLES          |
// |               consecutive HREADY=0 cycles (done with err=1).               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module boot_bus_translator
  import boot_bus_pkg::*;
#(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pAHB_DATA_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 128,
  parameter int pTIMEOUT_CYCLES    = 256
) (
  input  wire                   clk,
  input  wire                   rst,
  boot_bus_translator_if.master bus
);

  // Burst base is 16-byte aligned: the low nibble of the request address is dropped.
  localparam logic [pAHB_ADDR_WIDTH-1:0] c_align_mask = ~pAHB_ADDR_WIDTH'(4'hF);

  if ((pPAYLOAD_SIZE_BITS != BEATS * pAHB_DATA_WIDTH) || (pTIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("boot_bus_translator: payload must be 4 data words and timeout must be >= 1");
  end

  state_t                        r_state;
  logic [1:0]                    r_beat;      // beat index of the address phase on the bus
  logic [pAHB_ADDR_WIDTH-1:0]    r_base;
  logic [pPAYLOAD_SIZE_BITS-1:0] r_payload;

  logic [pAHB_ADDR_WIDTH-1:0]    r_haddr;
  htrans_t                       r_htrans;
  logic                          r_hwrite;
  logic [pAHB_DATA_WIDTH-1:0]    r_hwdata;
  logic                          r_done;
  logic                          r_err;
  logic [pPAYLOAD_SIZE_BITS-1:0] r_rd_data;

  logic [1:0]                    w_next_beat;
  logic [1:0]                    w_cap_idx;
  logic                          w_timeout;

  assign w_next_beat = r_beat + 2'd1;
  // In BURST the data phase lags the address phase by one beat; in LAST it is beat 3.
  assign w_cap_idx   = (r_state == ST_LAST) ? 2'd3 : (r_beat - 2'd1);

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(pTIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_busy;

  assign w_busy = (r_state == ST_ADDR) || (r_state == ST_BURST) ||
                  (r_state == ST_LAST) || (r_state == ST_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (!w_busy || bus.HREADY) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Fires on the stalled cycle that brings the count to pTIMEOUT_CYCLES.
  assign w_timeout = w_busy && !bus.HREADY && (r_to_cnt == TO_W'(pTIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_beat    <= 2'd0;
      r_base    <= '0;
      r_payload <= '0;
      r_haddr   <= '0;
      r_htrans  <= HTRANS_IDLE;
      r_hwrite  <= 1'b0;
      r_hwdata  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_timeout) begin
        r_htrans <= HTRANS_IDLE;
        r_state  <= ST_DONE;
        r_done   <= 1'b1;
        r_err    <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.bootControl_bus_go) begin
              r_base    <= bus.bootControl_bus_addr & c_align_mask;
              r_payload <= bus.bootControl_bus_write;
              r_haddr   <= bus.bootControl_bus_addr & c_align_mask;
              r_hwrite  <= bus.bootControl_bus_RW;
              r_htrans  <= HTRANS_NONSEQ;
              r_beat    <= 2'd0;
              r_err     <= 1'b0;
              r_state   <= ST_ADDR;
            end
          end

          ST_ADDR: begin
            if (bus.HREADY) begin
              r_hwdata <= r_payload[0 +: pAHB_DATA_WIDTH];
              r_haddr  <= r_base | pAHB_ADDR_WIDTH'({w_next_beat, 2'b00});
              r_htrans <= HTRANS_SEQ;
              r_beat   <= w_next_beat;
              r_state  <= ST_BURST;
            end
          end

          ST_BURST: begin
            if (bus.HRESP && !bus.HREADY) begin
              // First cycle of a two-cycle ERROR response: cancel the rest of the burst.
              r_htrans <= HTRANS_IDLE;
              r_state  <= ST_ERR;
            end else if (bus.HREADY) begin
              if (!r_hwrite) begin
                r_rd_data[int'(w_cap_idx)*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH] <= bus.HRDATA;
              end
              r_hwdata <= r_payload[int'(r_beat)*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH];
              if (r_beat == 2'd3) begin
                r_htrans <= HTRANS_IDLE;
                r_state  <= ST_LAST;
              end else begin
                r_haddr <= r_base | pAHB_ADDR_WIDTH'({w_next_beat, 2'b00});
                r_beat  <= w_next_beat;
              end
            end
          end

          ST_LAST: begin
            if (bus.HRESP && !bus.HREADY) begin
              r_state <= ST_ERR;
            end else if (bus.HREADY) begin
              if (!r_hwrite) begin
                r_rd_data[int'(w_cap_idx)*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH] <= bus.HRDATA;
              end
              r_done  <= 1'b1;
              r_err   <= 1'b0;
              r_state <= ST_DONE;
            end
          end

          ST_ERR: begin
            // Wait out the second ERROR cycle before reporting.
            if (bus.HREADY) begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end
          end

          ST_DONE: begin
            r_err    <= 1'b0;
            r_hwrite <= 1'b0;
            r_state  <= ST_IDLE;
          end

          default: begin
            r_htrans <= HTRANS_IDLE;
            r_state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.HADDR                  = r_haddr;
  assign bus.HTRANS                 = r_htrans;
  assign bus.HWRITE                 = r_hwrite;
  assign bus.HSIZE                  = HSIZE_WORD;
  assign bus.HBURST                 = HBURST_INCR4;
  assign bus.HWDATA                 = r_hwdata;
  assign bus.bootControl_bus_done   = r_done;
  assign bus.bootControl_bus_err    = r_err;
  assign bus.bootControl_bus_rdData = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_boot_bus_translator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_boot_bus_translator                                       |
// | Description : Self-checking bench for boot_bus_translator. Stimulus pushes |
// |               expected address phases, write beats and completions into    |
// |               queues; a combined AHB slave/monitor process pops them as    |
// |               the DUT presents each event.                                 |
// | Options     : BUS_TIMEOUT_EN enables the stall-timeout scenario.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_boot_bus_translator;
  import boot_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = 128;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
  } aph_t;

  typedef struct {
    logic         err;
    logic [127:0] rd;
    int           lat;
  } cpl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int go_cyc   = 0;

  aph_t        exp_aph[$];
  logic [31:0] exp_wd[$];
  cpl_t        exp_cpl[$];

  // Slave behaviour knobs, set by the stimulus per scenario.
  int          stall_beat = -1;
  int          stall_len  = 0;
  int          err_beat   = -1;
  bit          hold_low   = 1'b0;
  logic [31:0] rd_words[4];

  boot_bus_translator_if #(.pAHB_ADDR_WIDTH(AW), .pAHB_DATA_WIDTH(DW), .pPAYLOAD_SIZE_BITS(PW)) bus ();

  boot_bus_translator #(
    .pAHB_ADDR_WIDTH   (AW),
    .pAHB_DATA_WIDTH   (DW),
    .pPAYLOAD_SIZE_BITS(PW),
    .pTIMEOUT_CYCLES   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  task automatic push_aph(input logic [31:0] base, input logic wr, input int n);
    for (int k = 0; k < n; k++) begin
      aph_t a;
      a.addr  = base + 32'(4 * k);
      a.trans = (k == 0) ? 2'b10 : 2'b11;
      a.write = wr;
      exp_aph.push_back(a);
    end
  endtask

  task automatic push_cpl(input logic err, input logic [127:0] rd, input int lat);
    cpl_t c;
    c.err = err;
    c.rd  = rd;
    c.lat = lat;
    exp_cpl.push_back(c);
  endtask

  task automatic pulse_go(input logic [31:0] addr, input logic rw, input logic [127:0] payload);
    @(posedge clk);
    #1;
    bus.bootControl_bus_go    = 1'b1;
    bus.bootControl_bus_addr  = addr;
    bus.bootControl_bus_RW    = rw;
    bus.bootControl_bus_write = payload;
    go_cyc = cyc;
    @(posedge clk);
    #1;
    bus.bootControl_bus_go = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60 && exp_cpl.size() != 0; i++) @(posedge clk);
    if (exp_cpl.size() != 0) begin
      unexpected({name, "_timeout"});
      exp_cpl.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  // AHB slave model and output monitor. Responses are driven mid-cycle and
  // the DUT outputs are checked in the same step.
  initial begin : slave_monitor
    bit          dp_valid;
    bit          dp_write;
    bit          err_first;
    bit          prev_stall;
    bit          prev_err1;
    bit          rdy;
    bit          rerr;
    int          dp_idx;
    int          waits_left;
    logic [31:0] prev_haddr;
    logic [1:0]  prev_htrans;
    aph_t        a;
    cpl_t        c;
    logic [31:0] w;
    dp_valid = 0; dp_write = 0; err_first = 0; prev_stall = 0; prev_err1 = 0;
    dp_idx = 0; waits_left = 0; prev_haddr = '0; prev_htrans = '0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dp_valid   = 0;
        prev_stall = 0;
        prev_err1  = 0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
      end else begin
        rdy  = 1;
        rerr = 0;
        if (hold_low) begin
          rdy = 0;
        end else if (dp_valid) begin
          if (dp_idx == err_beat) begin
            rerr = 1;
            if (!err_first) begin
              rdy = 0;
              err_first = 1;
            end
          end else if (dp_idx == stall_beat && waits_left > 0) begin
            rdy = 0;
            waits_left--;
          end
        end
        bus.HREADY = rdy;
        bus.HRESP  = rerr;
        bus.HRDATA = (dp_valid && rdy && !rerr) ? rd_words[dp_idx] : (32'hBAD0_0000 | 32'(dp_idx));

        if (prev_stall) begin
          chk("hold_haddr", 128'(bus.HADDR), 128'(prev_haddr));
          chk("hold_htrans", 128'(bus.HTRANS), 128'(prev_htrans));
        end
        if (prev_err1) chk("err_htrans_idle", 128'(bus.HTRANS), 128'(2'b00));

        if (bus.HTRANS[1] && rdy) begin
          if (exp_aph.size() == 0) begin
            unexpected("aph_unexpected");
          end else begin
            a = exp_aph.pop_front();
            chk("aph_haddr", 128'(bus.HADDR), 128'(a.addr));
            chk("aph_htrans", 128'(bus.HTRANS), 128'(a.trans));
            chk("aph_hwrite", 128'(bus.HWRITE), 128'(a.write));
          end
        end

        if (dp_valid && dp_write && rdy && !rerr) begin
          if (exp_wd.size() == 0) begin
            unexpected("wdata_unexpected");
          end else begin
            w = exp_wd.pop_front();
            chk("hwdata", 128'(bus.HWDATA), 128'(w));
          end
        end

        if (bus.bootControl_bus_done) begin
          if (exp_cpl.size() == 0) begin
            unexpected("done_unexpected");
          end else begin
            c = exp_cpl.pop_front();
            chk("done_err", 128'(bus.bootControl_bus_err), 128'(c.err));
            chk("done_rddata", bus.bootControl_bus_rdData, c.rd);
            chk("done_latency", 128'(cyc - go_cyc), 128'(c.lat));
          end
        end

        prev_stall  = bus.HTRANS[1] && !rdy && !rerr && !hold_low;
        prev_err1   = rerr && !rdy;
        prev_haddr  = bus.HADDR;
        prev_htrans = bus.HTRANS;
        if (rdy) begin
          dp_valid   = bus.HTRANS[1];
          dp_write   = bus.HWRITE;
          dp_idx     = int'(bus.HADDR[3:2]);
          waits_left = (dp_idx == stall_beat) ? stall_len : 0;
          err_first  = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected to have finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.bootControl_bus_go    = 1'b0;
    bus.bootControl_bus_addr  = '0;
    bus.bootControl_bus_write = '0;
    bus.bootControl_bus_RW    = 1'b0;
    for (int k = 0; k < 4; k++) rd_words[k] = 32'hEEEE_EEEE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_htrans", 128'(bus.HTRANS), 128'(2'b00));
    chk("rst_haddr", 128'(bus.HADDR), 128'(0));
    chk("rst_hwrite", 128'(bus.HWRITE), 128'(0));
    chk("rst_hwdata", 128'(bus.HWDATA), 128'(0));
    chk("rst_done", 128'(bus.bootControl_bus_done), 128'(0));
    chk("rst_err", 128'(bus.bootControl_bus_err), 128'(0));
    chk("rst_rddata", bus.bootControl_bus_rdData, 128'(0));
    chk("hsize", 128'(bus.HSIZE), 128'(3'b010));
    chk("hburst", 128'(bus.HBURST), 128'(3'b011));
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Write burst, unaligned request address, zero wait states.
    push_aph(32'h1000_0000, 1'b1, 4);
    exp_wd.push_back(32'h1111_1111);
    exp_wd.push_back(32'h2222_2222);
    exp_wd.push_back(32'h3333_3333);
    exp_wd.push_back(32'h4444_4444);
    push_cpl(1'b0, 128'h0, 6);
    pulse_go(32'h1000_0008, 1'b1, 128'h44444444_33333333_22222222_11111111);
    wait_done("write");

    // Read burst, zero wait states.
    rd_words[0] = 32'h0000_00A0; rd_words[1] = 32'h0000_00B1;
    rd_words[2] = 32'h0000_00C2; rd_words[3] = 32'h0000_00D3;
    push_aph(32'h2000_0000, 1'b0, 4);
    push_cpl(1'b0, 128'h000000D3_000000C2_000000B1_000000A0, 6);
    pulse_go(32'h2000_0000, 1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    wait_done("read");

    // Read with three wait states on the data phase of beat 2.
    rd_words[0] = 32'hCAFE_0000; rd_words[1] = 32'hCAFE_0001;
    rd_words[2] = 32'hCAFE_0002; rd_words[3] = 32'hCAFE_0003;
    stall_beat = 2;
    stall_len  = 3;
    push_aph(32'h3000_0040, 1'b0, 4);
    push_cpl(1'b0, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 9);
    pulse_go(32'h3000_0040, 1'b0, 128'h0);
    wait_done("read_wait");
    stall_beat = -1;
    stall_len  = 0;

    // ERROR response on beat 1: only beat 0 is captured, remaining words keep old data.
    rd_words[0] = 32'h0BAD_F00D; rd_words[1] = 32'h1234_5678;
    rd_words[2] = 32'h9ABC_DEF0; rd_words[3] = 32'h0F0F_0F0F;
    err_beat = 1;
    push_aph(32'h4000_0000, 1'b0, 2);
    push_cpl(1'b1, 128'hCAFE0003_CAFE0002_CAFE0001_0BADF00D, 5);
    pulse_go(32'h4000_0000, 1'b0, 128'h0);
    wait_done("error");
    err_beat = -1;

    // Second go while busy is ignored; reset mid-burst aborts with no done.
    push_aph(32'h5000_0000, 1'b1, 2);
    exp_wd.push_back(32'h5555_5555);
    pulse_go(32'h5000_0000, 1'b1, 128'h88888888_77777777_66666666_55555555);
    @(posedge clk);
    #1;
    bus.bootControl_bus_go   = 1'b1;
    bus.bootControl_bus_addr = 32'h7000_0000;
    @(posedge clk);
    #1;
    bus.bootControl_bus_go = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_htrans", 128'(bus.HTRANS), 128'(2'b00));
    chk("midrst_haddr", 128'(bus.HADDR), 128'(0));
    chk("midrst_hwrite", 128'(bus.HWRITE), 128'(0));
    chk("midrst_hwdata", 128'(bus.HWDATA), 128'(0));
    chk("midrst_done", 128'(bus.bootControl_bus_done), 128'(0));
    chk("midrst_rddata", bus.bootControl_bus_rdData, 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);

    // Clean read burst after the reset.
    rd_words[0] = 32'h0102_0304; rd_words[1] = 32'h0506_0708;
    rd_words[2] = 32'h090A_0B0C; rd_words[3] = 32'h0D0E_0F10;
    push_aph(32'h6000_0010, 1'b0, 4);
    push_cpl(1'b0, 128'h0D0E0F10_090A0B0C_05060708_01020304, 6);
    pulse_go(32'h6000_001C, 1'b0, 128'h0);
    wait_done("read_after_rst");

`ifdef BUS_TIMEOUT_EN
    // HREADY held low from the first address phase: abort after 8 stalled cycles.
    hold_low = 1'b1;
    push_cpl(1'b1, 128'h0D0E0F10_090A0B0C_05060708_01020304, 9);
    pulse_go(32'h8000_0000, 1'b0, 128'h0);
    wait_done("timeout");
    hold_low = 1'b0;
    repeat (2) @(posedge clk);
`endif

    chk("aph_queue_left", 128'(exp_aph.size()), 128'(0));
    chk("wdata_queue_left", 128'(exp_wd.size()), 128'(0));
    chk("cpl_queue_left", 128'(exp_cpl.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
